// File: rtl/fp_addsub_align_stage.sv
// FP16 add/sub front end: unpack, magnitude compare/swap, then align the smaller mantissa with GRS+sticky.
// Optional build macro FPALIGN_SUBNORMAL_EN keeps E==0 mantissas as subnormals; otherwise they flush to zero.
module fp_addsub_align_stage #(
   parameter int EXP_W = 5,
   parameter int MAN_W = 10,
   parameter int DW    = 1 + EXP_W + MAN_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [DW-1:0]      a,
   input  logic [DW-1:0]      b,
   input  logic               ctrl,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               sa,
   output logic               sb,
   output logic               ctrl_o,
   output logic               max_ab,
   output logic               op_eff,
   output logic [EXP_W-1:0]   cexp,
   output logic [MAN_W:0]     m_max,
   output logic [MAN_W+3:0]   m_min_al
);

   localparam int AW = MAN_W + 4;
   localparam logic [EXP_W-1:0] AW_E = EXP_W'(AW);

   logic s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
   logic s1_adv, in_fire;

   assign s1_adv     = s1_valid_q & (~s2_valid_q | out_ready);
   assign in_ready   = ~s1_valid_q | s1_adv;
   assign in_fire    = in_valid & in_ready;
   assign out_valid  = s2_valid_q;
   assign s1_valid_d = in_fire | (s1_valid_q & ~s1_adv);
   assign s2_valid_d = s1_adv | (s2_valid_q & ~out_ready);

   // Stage 1: unpack, compare raw {E,M} magnitudes, swap larger operand into the max slot.
   logic [EXP_W-1:0] ea, eb, eea, eeb;
   logic [MAN_W-1:0] ma, mb;
   logic             swap_d;
   logic [EXP_W-1:0] cexp_d, shamt_d;
   logic [MAN_W:0]   mmax_d, mmin_d;

   always_comb begin
      ea = a[DW-2 -: EXP_W];
      eb = b[DW-2 -: EXP_W];
`ifdef FPALIGN_SUBNORMAL_EN
      ma = a[MAN_W-1:0];
      mb = b[MAN_W-1:0];
`else
      ma = (ea == '0) ? '0 : a[MAN_W-1:0];
      mb = (eb == '0) ? '0 : b[MAN_W-1:0];
`endif
      eea    = (ea == '0) ? EXP_W'(1) : ea;
      eeb    = (eb == '0) ? EXP_W'(1) : eb;
      swap_d = {eb, mb} > {ea, ma};
      if (swap_d) begin
         cexp_d  = eeb;
         mmax_d  = {|eb, mb};
         mmin_d  = {|ea, ma};
         shamt_d = eeb - eea;
      end else begin
         cexp_d  = eea;
         mmax_d  = {|ea, ma};
         mmin_d  = {|eb, mb};
         shamt_d = eea - eeb;
      end
   end

   logic             s1_sa_q, s1_sb_q, s1_ctrl_q, s1_swap_q;
   logic [EXP_W-1:0] s1_cexp_q, s1_shamt_q;
   logic [MAN_W:0]   s1_mmax_q, s1_mmin_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid_q <= 1'b0;
         s1_sa_q    <= 1'b0;
         s1_sb_q    <= 1'b0;
         s1_ctrl_q  <= 1'b0;
         s1_swap_q  <= 1'b0;
         s1_cexp_q  <= '0;
         s1_shamt_q <= '0;
         s1_mmax_q  <= '0;
         s1_mmin_q  <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         if (in_fire) begin
            s1_sa_q    <= a[DW-1];
            s1_sb_q    <= b[DW-1];
            s1_ctrl_q  <= ctrl;
            s1_swap_q  <= swap_d;
            s1_cexp_q  <= cexp_d;
            s1_shamt_q <= shamt_d;
            s1_mmax_q  <= mmax_d;
            s1_mmin_q  <= mmin_d;
         end
      end
   end

   // Stage 2: right shift into the GRS field; anything shifted past bit 0 folds into the sticky bit.
   logic [AW-1:0] fld, shifted, lost_mask, align_d;

   always_comb begin
      fld       = {s1_mmin_q, 3'b000};
      shifted   = fld >> s1_shamt_q;
      lost_mask = ~({AW{1'b1}} << s1_shamt_q);
      if (s1_shamt_q < AW_E) begin
         align_d = {shifted[AW-1:1], shifted[0] | (|(fld & lost_mask))};
      end else begin
         align_d = {{(AW-1){1'b0}}, |s1_mmin_q};
      end
   end

   logic             sa_q, sb_q, ctrl_q, max_ab_q, op_eff_q;
   logic [EXP_W-1:0] cexp_q;
   logic [MAN_W:0]   m_max_q;
   logic [AW-1:0]    m_min_al_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s2_valid_q <= 1'b0;
         sa_q       <= 1'b0;
         sb_q       <= 1'b0;
         ctrl_q     <= 1'b0;
         max_ab_q   <= 1'b0;
         op_eff_q   <= 1'b0;
         cexp_q     <= '0;
         m_max_q    <= '0;
         m_min_al_q <= '0;
      end else begin
         s2_valid_q <= s2_valid_d;
         if (s1_adv) begin
            sa_q       <= s1_sa_q;
            sb_q       <= s1_sb_q;
            ctrl_q     <= s1_ctrl_q;
            max_ab_q   <= s1_swap_q;
            op_eff_q   <= s1_ctrl_q ^ s1_sa_q ^ s1_sb_q;
            cexp_q     <= s1_cexp_q;
            m_max_q    <= s1_mmax_q;
            m_min_al_q <= align_d;
         end
      end
   end

   assign sa       = sa_q;
   assign sb       = sb_q;
   assign ctrl_o   = ctrl_q;
   assign max_ab   = max_ab_q;
   assign op_eff   = op_eff_q;
   assign cexp     = cexp_q;
   assign m_max    = m_max_q;
   assign m_min_al = m_min_al_q;

endmodule

// File: tb/tb_fp_addsub_align_stage.sv
// Bench for fp_addsub_align_stage: integer-arithmetic reference model with a scoreboard queue,
// plus hand-computed literal expectations for the directed vectors.
module tb_fp_addsub_align_stage;

   logic        clk = 1'b0;
   logic        reset, in_valid, in_ready, ctrl, out_valid, out_ready;
   logic [15:0] a, b;
   logic        sa, sb, ctrl_o, max_ab, op_eff;
   logic [4:0]  cexp;
   logic [10:0] m_max;
   logic [13:0] m_min_al;

   fp_addsub_align_stage dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .ctrl(ctrl), .out_valid(out_valid), .out_ready(out_ready),
      .sa(sa), .sb(sb), .ctrl_o(ctrl_o), .max_ab(max_ab), .op_eff(op_eff),
      .cexp(cexp), .m_max(m_max), .m_min_al(m_min_al)
   );

   always #5 clk = ~clk;

   typedef struct {
      int sa, sb, ctrl_o, max_ab, op_eff, cexp, m_max, m_min_al;
   } res_t;

   res_t q[$];
   res_t mon_e;
   int   n_chk  = 0;
   int   n_fail = 0;
   int   n_pop  = 0;

`ifdef FPALIGN_SUBNORMAL_EN
   localparam int SUBN = 1;
`else
   localparam int SUBN = 0;
`endif

   // Reference: treat fields as plain integers; the smaller significand is scaled by 8 (GRS),
   // divided by 2^shift, and any nonzero remainder sets bit 0.
   function automatic res_t model(input int x, input int y, input int c);
      res_t r;
      int ex, ey, mx, my, px, py, gx, gy, big_e, small_e, small_g, sh, full, quo, rem;
      ex = (x >> 10) & 31;  mx = x & 1023;
      ey = (y >> 10) & 31;  my = y & 1023;
      if (SUBN == 0) begin
         if (ex == 0) mx = 0;
         if (ey == 0) my = 0;
      end
      r.sa     = (x >> 15) & 1;
      r.sb     = (y >> 15) & 1;
      r.ctrl_o = c;
      r.op_eff = r.sa ^ r.sb ^ c;
      r.max_ab = ((ey * 1024 + my) > (ex * 1024 + mx)) ? 1 : 0;
      px = (ex == 0) ? 1 : ex;
      py = (ey == 0) ? 1 : ey;
      gx = ((ex != 0) ? 1024 : 0) + mx;
      gy = ((ey != 0) ? 1024 : 0) + my;
      if (r.max_ab == 1) begin
         big_e = py; r.m_max = gy; small_e = px; small_g = gx;
      end else begin
         big_e = px; r.m_max = gx; small_e = py; small_g = gy;
      end
      r.cexp = big_e;
      sh     = big_e - small_e;
      full   = small_g * 8;
      if (sh < 14) begin
         quo = full / (1 << sh);
         rem = full % (1 << sh);
         r.m_min_al = quo | ((rem != 0) ? 1 : 0);
      end else begin
         r.m_min_al = (small_g != 0) ? 1 : 0;
      end
      return r;
   endfunction

   task automatic check(input string nm, input int act, input int req);
      n_chk++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
      end
   endtask

   // Compare process: every negedge with out_valid the outputs must equal the oldest expected entry.
   always @(negedge clk) begin
      if (reset) begin
         q.delete();
      end else begin
         if (out_valid) begin
            if (q.size() == 0) begin
               check("unexpected_out_valid", 1, 0);
            end else begin
               mon_e = q[0];
               check("mdl_sa",       int'(sa),       mon_e.sa);
               check("mdl_sb",       int'(sb),       mon_e.sb);
               check("mdl_ctrl_o",   int'(ctrl_o),   mon_e.ctrl_o);
               check("mdl_max_ab",   int'(max_ab),   mon_e.max_ab);
               check("mdl_op_eff",   int'(op_eff),   mon_e.op_eff);
               check("mdl_cexp",     int'(cexp),     mon_e.cexp);
               check("mdl_m_max",    int'(m_max),    mon_e.m_max);
               check("mdl_m_min_al", int'(m_min_al), mon_e.m_min_al);
               if (out_ready) begin
                  void'(q.pop_front());
                  n_pop++;
               end
            end
         end
         if (in_valid && in_ready) q.push_back(model(int'(a), int'(b), int'(ctrl)));
      end
   end

   // Called just after a posedge; returns just after the posedge that accepted the pair.
   task automatic send(input logic [15:0] xa, input logic [15:0] xb, input logic xc);
      logic acc;
      a = xa; b = xb; ctrl = xc; in_valid = 1'b1; acc = 1'b0;
      for (int k = 0; k < 50 && !acc; k++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
      end
      if (!acc) check("send_timeout", 0, 1);
      in_valid = 1'b0;
   endtask

   task automatic wait_out(input string nm);
      int k;
      k = 0;
      @(negedge clk);
      while (!out_valid && k < 20) begin
         @(negedge clk);
         k++;
      end
      if (!out_valid) check({nm, "_timeout"}, 0, 1);
   endtask

   task automatic lit(input string nm, input logic [15:0] xa, input logic [15:0] xb, input logic xc,
                      input int e_sa, input int e_sb, input int e_max, input int e_cexp,
                      input int e_mmax, input int e_mmin, input int e_op);
      send(xa, xb, xc);
      wait_out(nm);
      check({nm, "_sa"},       int'(sa),       e_sa);
      check({nm, "_sb"},       int'(sb),       e_sb);
      check({nm, "_max_ab"},   int'(max_ab),   e_max);
      check({nm, "_cexp"},     int'(cexp),     e_cexp);
      check({nm, "_m_max"},    int'(m_max),    e_mmax);
      check({nm, "_m_min_al"}, int'(m_min_al), e_mmin);
      check({nm, "_op_eff"},   int'(op_eff),   e_op);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int pops0;
      reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; ctrl = 1'b0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_in_ready",  int'(in_ready),  1);
      check("rst_m_min_al",  int'(m_min_al),  0);
      check("rst_cexp",      int'(cexp),      0);
      check("rst_m_max",     int'(m_max),     0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      lit("t1",   16'h3C00, 16'h3C00, 1'b0, 0, 0, 0, 15, 'h400, 'h2000, 0);
      lit("t2",   16'h3800, 16'hBC00, 1'b0, 0, 1, 1, 15, 'h400, 'h1000, 1);
      lit("t3",   16'h3C00, 16'h0001, 1'b0, 0, 0, 0, 15, 'h400, (SUBN != 0) ? 'h1 : 'h0, 0);
      lit("t4a",  16'h3C01, 16'h3001, 1'b0, 0, 0, 0, 15, 'h401, 'h401, 0);
      lit("t4b",  16'h3C01, 16'h2C03, 1'b0, 0, 0, 0, 15, 'h401, 'h201, 0);
      lit("nz",   16'h8000, 16'h0000, 1'b0, 1, 0, 0, 1, 'h0, 'h0, 1);
      lit("inf",  16'h7C00, 16'h3C00, 1'b1, 0, 0, 0, 31, 'h400, 'h1, 1);
      lit("sh13", 16'h3C00, 16'h0800, 1'b0, 0, 0, 0, 15, 'h400, 'h1, 0);
      lit("e0",   16'h0200, 16'h0100, 1'b0, 0, 0, 0, 1,
          (SUBN != 0) ? 'h200 : 'h0, (SUBN != 0) ? 'h800 : 'h0, 0);
      lit("tie",  16'hC400, 16'h4400, 1'b1, 1, 0, 0, 17, 'h400, 'h2000, 0);

      // Back-to-back stream into a stalled output.
      out_ready = 1'b0;
      pops0 = n_pop;
      fork
         begin
            send(16'h4000, 16'h3C00, 1'b0);
            send(16'h4400, 16'h3800, 1'b1);
            send(16'hC200, 16'h4100, 1'b0);
            send(16'h3555, 16'h2AAA, 1'b1);
         end
         begin
            repeat (3) @(negedge clk);
            check("t5_in_ready_stall",  int'(in_ready),  0);
            check("t5_out_valid_stall", int'(out_valid), 1);
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      for (int k = 0; k < 30 && (n_pop - pops0) < 4; k++) @(negedge clk);
      check("t5_result_count", n_pop - pops0, 4);
      @(posedge clk);
      #1;

      // Reset with two transactions in flight.
      out_ready = 1'b0;
      send(16'h3C00, 16'h3800, 1'b0);
      send(16'h4000, 16'h3C00, 1'b1);
      check("t6_inflight", int'(out_valid), 1);
      #2;
      reset = 1'b1;
      #1;
      check("t6_rst_out_valid", int'(out_valid), 0);
      check("t6_rst_in_ready",  int'(in_ready),  1);
      check("t6_rst_m_min_al",  int'(m_min_al),  0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      out_ready = 1'b1;
      a = 16'h3C00; b = 16'h3400; ctrl = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      check("t6_lat0", int'(out_valid), 0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      check("t6_lat1", int'(out_valid), 0);
      @(negedge clk);
      check("t6_lat2", int'(out_valid), 1);
      check("t6_lat2_m_min_al", int'(m_min_al), 'h800);
      repeat (3) @(negedge clk);
      check("final_queue_empty", q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
